servo_sweep_ctrl: RTL and testbench
===================================

Name: servo_sweep_ctrl

Overview:
Sequencing controller for the servo PWM generator datapath. It owns the duty-cycle word the generator compares against its period counter, and it sets that word in one of two modes. In manual mode, debounced one-shot inc/dec button pulses step the target. In auto mode, an internal FSM sweeps between limits with a dwell at each end. Changes are slew-limited and applied only at PWM frame boundaries, so the servo never sees a mid-period glitch or a large jump.

Parameters:
DUTY_W, 32, width of duty word (clk counts of high time)
DUTY_MIN, 25_000, lowest legal duty (0.5 ms at 50 MHz)
DUTY_MAX, 125_000, highest legal duty (2.5 ms at 50 MHz)
DUTY_RST, 75_000, duty and target value after reset
STEP, 5_000, target change per inc/dec pulse
RAMP, 1_000, maximum duty change per frame
DWELL_FRAMES, 25, frames held at each sweep limit (auto mode)

Ports:
clk  in  1  clock
rst_a_p  in  1  reset, asynchronous, active-high
frame_tick  in  1  1-cycle pulse when the PWM period counter wraps to 0
inc_pulse  in  1  debounced one-shot: increase target by STEP
dec_pulse  in  1  debounced one-shot: decrease target by STEP
mode_auto  in  1  level: 1 = auto sweep, 0 = manual
hold  in  1  level: freeze slew and dwell; frame_tick ignored while high
duty  out  DUTY_W  registered duty word to the PWM comparator
duty_upd  out  1  1-cycle strobe, high in the cycle duty changes
at_limit  out  1  duty == DUTY_MIN or duty == DUTY_MAX
state_o  out  3  current FSM state encoding, for debug/LEDs

Behaviour:
- Reset (async, any state, including mid-ramp or mid-dwell) sets:
  - duty = target = DUTY_RST
  - duty_upd = 0
  - dwell count = 0
  - state = MANUAL
  - at_limit is a combinational function of duty, so 0 at default parameters.
- States: MANUAL, SWEEP_UP, DWELL_HI, SWEEP_DN, DWELL_LO.
- MANUAL:
  - inc_pulse alone: target = min(target+STEP, DUTY_MAX).
  - dec_pulse alone: target = max(target-STEP, DUTY_MIN).
  - inc and dec in the same cycle: ignored.
  - Saturation arithmetic is done at DUTY_W+1 bits; no wrap-around.
- Slew (all states):
  - On frame_tick with hold = 0 and duty != target:
    - if |target-duty| <= RAMP, duty = target;
    - otherwise duty moves RAMP toward target.
  - duty is registered: it changes in the cycle after frame_tick, and duty_upd is high in exactly that cycle.
  - No change in duty means no strobe.
- Auto mode:
  - mode_auto sampled 1 while in MANUAL: go to SWEEP_UP, target = DUTY_MAX.
  - SWEEP_UP: when duty == DUTY_MAX, go to DWELL_HI and clear the dwell count.
  - DWELL_HI / DWELL_LO: count frame_ticks (hold = 0). After DWELL_FRAMES ticks:
    - DWELL_HI goes to SWEEP_DN, target = DUTY_MIN;
    - DWELL_LO goes to SWEEP_UP, target = DUTY_MAX.
  - SWEEP_DN: when duty == DUTY_MIN, go to DWELL_LO.
  - inc/dec pulses are ignored in every auto state.
- mode_auto sampled 0 in any auto state:
  - go to MANUAL next cycle and set target = current duty (servo stops where it is);
  - clear the dwell count.
- hold:
  - frame_ticks are discarded: no slew, no dwell count;
  - button pulses in MANUAL still update the target.
- Frame alignment: the PWM datapath samples duty on its period wrap. Because duty only changes the cycle after frame_tick, a period always uses one duty value.

Decomposition:
- Package servo_ctrl_pkg holds:
  - the state enum (3-bit encoding: MANUAL=0, SWEEP_UP=1, DWELL_HI=2, SWEEP_DN=3, DWELL_LO=4);
  - default constants DUTY_MIN/MAX/RST, STEP, RAMP, DWELL_FRAMES;
  - the CLK_HZ = 50_000_000 and FRAME_HZ = 50 constants shared with the PWM generator.
- One sub-module: servo_slew.
  - Inputs: target, frame_tick, hold.
  - Outputs: the duty register and duty_upd.
  - Owns the saturating slew step.
  - The top level keeps the FSM, target register and dwell counter.

Test Plan:
- Reset then 3 frame_ticks -> duty = 75000, duty_upd never high, state_o = 0, at_limit = 0.
- MANUAL, one inc_pulse, then 6 frame_ticks -> target 80000.
  - duty goes 76000, 77000, 78000, 79000, 80000, each with a 1-cycle duty_upd one cycle after the tick.
  - 6th tick: no strobe.
- 12 inc_pulses from reset, then 60 ticks -> target saturates at 125000, duty reaches 125000 on tick 50, at_limit = 1.
  - inc and dec asserted together -> target unchanged.
- mode_auto = 1 from 75000 -> SWEEP_UP.
  - Duty reaches 125000 after 50 ticks, DWELL_HI for 25 ticks, then SWEEP_DN to 25000 after 100 ticks, DWELL_LO, then SWEEP_UP.
  - inc_pulse during the sweep has no effect.
- Auto, duty = 100000 in SWEEP_DN, drop mode_auto -> MANUAL, target = 100000, no further duty change.
  - hold = 1 during a manual ramp -> duty frozen across 5 ticks, resumes on release.
- Assert rst_a_p mid-ramp (duty = 90000, target 110000) asynchronously between clock edges -> duty = 75000, state MANUAL immediately.
  - After release, no duty_upd until target changes.

Source files
------------

// File: rtl/servo_ctrl_pkg.sv
// Shared types and default constants for the servo sweep controller and the
// PWM generator it feeds.
package servo_ctrl_pkg;

   // Controller state; the encoding is visible on state_o for debug/LEDs.
   typedef enum logic [2:0] {
      ST_MANUAL   = 3'd0,
      ST_SWEEP_UP = 3'd1,
      ST_DWELL_HI = 3'd2,
      ST_SWEEP_DN = 3'd3,
      ST_DWELL_LO = 3'd4
   } servo_state_t;

   // Timing base shared with the PWM generator (20 ms frame at 50 MHz).
   localparam int unsigned CLK_HZ   = 50_000_000;
   localparam int unsigned FRAME_HZ = 50;

   // Default duty limits and motion profile, in clk counts of high time.
   localparam int unsigned DEF_DUTY_W       = 32;
   localparam int unsigned DEF_DUTY_MIN     = 25_000;
   localparam int unsigned DEF_DUTY_MAX     = 125_000;
   localparam int unsigned DEF_DUTY_RST     = 75_000;
   localparam int unsigned DEF_STEP         = 5_000;
   localparam int unsigned DEF_RAMP         = 1_000;
   localparam int unsigned DEF_DWELL_FRAMES = 25;

endpackage

// File: rtl/servo_slew.sv
// Slew-limited duty register. On each accepted frame tick the duty word moves
// toward the target by at most RAMP counts, landing exactly on the target when
// it is within reach. duty_upd marks the single cycle in which duty changed.
module servo_slew
   import servo_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W   = DEF_DUTY_W,
   parameter int unsigned DUTY_RST = DEF_DUTY_RST,
   parameter int unsigned RAMP     = DEF_RAMP
) (
   input  logic              clk,
   input  logic              rst_a_p,
   input  logic [DUTY_W-1:0] target,
   input  logic              frame_tick,
   input  logic              hold,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd
);

   localparam logic [DUTY_W-1:0] RST_W  = DUTY_W'(DUTY_RST);
   localparam logic [DUTY_W-1:0] RAMP_W = DUTY_W'(RAMP);

   logic              move;
   logic              going_up;
   logic [DUTY_W-1:0] gap;
   logic [DUTY_W-1:0] next_duty;

   // Distance to target and the bounded step toward it. Target always lies
   // inside the legal window, so duty +/- RAMP cannot wrap when gap > RAMP.
   always_comb begin
      move      = frame_tick && !hold && (duty != target);
      going_up  = (target > duty);
      gap       = going_up ? (target - duty) : (duty - target);
      next_duty = target;
      if (gap > RAMP_W) begin
         next_duty = going_up ? (duty + RAMP_W) : (duty - RAMP_W);
      end
   end

   // Duty only changes the cycle after a frame tick, so a PWM period that
   // latches duty on its wrap always sees one stable value.
   always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         duty     <= RST_W;
         duty_upd <= 1'b0;
      end else begin
         duty_upd <= move;
         if (move) begin
            duty <= next_duty;
         end
      end
   end

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Servo duty sequencer. Owns the target register, the manual/auto-sweep FSM
// and the dwell counter; the slew-limited duty register lives in servo_slew.
module servo_sweep_ctrl
   import servo_ctrl_pkg::*;
#(
   parameter int unsigned DUTY_W       = DEF_DUTY_W,
   parameter int unsigned DUTY_MIN     = DEF_DUTY_MIN,
   parameter int unsigned DUTY_MAX     = DEF_DUTY_MAX,
   parameter int unsigned DUTY_RST     = DEF_DUTY_RST,
   parameter int unsigned STEP         = DEF_STEP,
   parameter int unsigned RAMP         = DEF_RAMP,
   parameter int unsigned DWELL_FRAMES = DEF_DWELL_FRAMES
) (
   input  logic              clk,
   input  logic              rst_a_p,
   input  logic              frame_tick,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
   input  logic              mode_auto,
   input  logic              hold,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd,
   output logic              at_limit,
   output logic [2:0]        state_o
);

   localparam int unsigned DWELL_CW = $clog2(DWELL_FRAMES + 1);

   localparam logic [DUTY_W-1:0]   MIN_W     = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0]   MAX_W     = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0]   RST_W     = DUTY_W'(DUTY_RST);
   localparam logic [DUTY_W-1:0]   STEP_W    = DUTY_W'(STEP);
   localparam logic [DUTY_W:0]     STEP_X    = (DUTY_W+1)'(STEP);
   localparam logic [DUTY_W:0]     MAX_X     = (DUTY_W+1)'(DUTY_MAX);
   localparam logic [DUTY_W:0]     DEC_FLOOR = (DUTY_W+1)'(DUTY_MIN) + (DUTY_W+1)'(STEP);
   localparam logic [DWELL_CW-1:0] DWELL_END = DWELL_CW'(DWELL_FRAMES - 1);

   servo_state_t      state;
   logic [DUTY_W-1:0] target;
   logic [DWELL_CW-1:0] dwell;

   logic              tick_ok;
   logic              dwell_last;
   logic [DUTY_W:0]   inc_sum;
   logic [DUTY_W-1:0] inc_target;
   logic [DUTY_W-1:0] dec_target;

   // Saturating button steps, evaluated one bit wider so nothing wraps.
   always_comb begin
      tick_ok    = frame_tick && !hold;
      dwell_last = (dwell == DWELL_END);
      inc_sum    = {1'b0, target} + STEP_X;
      inc_target = (inc_sum > MAX_X) ? MAX_W : inc_sum[DUTY_W-1:0];
      dec_target = ({1'b0, target} < DEC_FLOOR) ? MIN_W : (target - STEP_W);
   end

   // Mode FSM with target and dwell bookkeeping. Leaving auto mode parks the
   // target on the present duty so the servo stops where it is.
   always_ff @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         state  <= ST_MANUAL;
         target <= RST_W;
         dwell  <= '0;
      end else if (state != ST_MANUAL && !mode_auto) begin
         state  <= ST_MANUAL;
         target <= duty;
         dwell  <= '0;
      end else begin
         case (state)
            ST_MANUAL: begin
               if (mode_auto) begin
                  state  <= ST_SWEEP_UP;
                  target <= MAX_W;
               end else if (inc_pulse && !dec_pulse) begin
                  target <= inc_target;
               end else if (dec_pulse && !inc_pulse) begin
                  target <= dec_target;
               end
            end
            ST_SWEEP_UP: begin
               if (duty == MAX_W) begin
                  state <= ST_DWELL_HI;
                  dwell <= '0;
               end
            end
            ST_DWELL_HI: begin
               if (tick_ok) begin
                  if (dwell_last) begin
                     state  <= ST_SWEEP_DN;
                     target <= MIN_W;
                     dwell  <= '0;
                  end else begin
                     dwell <= dwell + 1'b1;
                  end
               end
            end
            ST_SWEEP_DN: begin
               if (duty == MIN_W) begin
                  state <= ST_DWELL_LO;
                  dwell <= '0;
               end
            end
            ST_DWELL_LO: begin
               if (tick_ok) begin
                  if (dwell_last) begin
                     state  <= ST_SWEEP_UP;
                     target <= MAX_W;
                     dwell  <= '0;
                  end else begin
                     dwell <= dwell + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_MANUAL;
               dwell <= '0;
            end
         endcase
      end
   end

   servo_slew #(
      .DUTY_W   (DUTY_W),
      .DUTY_RST (DUTY_RST),
      .RAMP     (RAMP)
   ) u_slew (
      .clk        (clk),
      .rst_a_p    (rst_a_p),
      .target     (target),
      .frame_tick (frame_tick),
      .hold       (hold),
      .duty       (duty),
      .duty_upd   (duty_upd)
   );

   assign at_limit = (duty == MIN_W) || (duty == MAX_W);
   assign state_o  = state;

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Bench for servo_sweep_ctrl: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a behavioural model.
module tb_servo_sweep_ctrl;

   localparam int MIN   = 25_000;
   localparam int MAX   = 125_000;
   localparam int RST   = 75_000;
   localparam int STEP  = 5_000;
   localparam int RAMP  = 1_000;
   localparam int DWELL = 25;

   logic        clk = 1'b0;
   logic        rst_a_p = 1'b1;
   logic        frame_tick = 1'b0;
   logic        inc_pulse = 1'b0;
   logic        dec_pulse = 1'b0;
   logic        mode_auto = 1'b0;
   logic        hold = 1'b0;
   logic [31:0] duty;
   logic        duty_upd;
   logic        at_limit;
   logic [2:0]  state_o;

   int n_cmp = 0;
   int n_bad = 0;
   int upd_cnt = 0;
   logic last_upd;

   // model: 0 manual, 1 up, 2 dwell hi, 3 down, 4 dwell lo
   int m_duty = RST, m_target = RST, m_state = 0, m_dwell = 0;
   bit m_upd = 0;
   int nd, nt, ns, nw;
   bit tk;

   servo_sweep_ctrl dut (
      .clk        (clk),
      .rst_a_p    (rst_a_p),
      .frame_tick (frame_tick),
      .inc_pulse  (inc_pulse),
      .dec_pulse  (dec_pulse),
      .mode_auto  (mode_auto),
      .hold       (hold),
      .duty       (duty),
      .duty_upd   (duty_upd),
      .at_limit   (at_limit),
      .state_o    (state_o)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // behavioural reference: what the outputs must be after each edge
   always @(posedge clk or posedge rst_a_p) begin
      if (rst_a_p) begin
         m_duty = RST; m_target = RST; m_state = 0; m_dwell = 0; m_upd = 0;
      end else begin
         tk = frame_tick && !hold;
         nd = m_duty; nt = m_target; ns = m_state; nw = m_dwell;
         m_upd = 0;
         if (tk && m_duty != m_target) begin
            if (m_target > m_duty) nd = imin(m_duty + RAMP, m_target);
            else                   nd = imax(m_duty - RAMP, m_target);
            m_upd = 1;
         end
         if (m_state == 0) begin
            if (mode_auto) begin ns = 1; nt = MAX; end
            else if (inc_pulse && !dec_pulse) nt = imin(m_target + STEP, MAX);
            else if (dec_pulse && !inc_pulse) nt = imax(m_target - STEP, MIN);
         end else if (!mode_auto) begin
            ns = 0; nt = m_duty; nw = 0;
         end else begin
            case (m_state)
               1: if (m_duty == MAX) begin ns = 2; nw = 0; end
               3: if (m_duty == MIN) begin ns = 4; nw = 0; end
               2, 4: if (tk) begin
                  nw = m_dwell + 1;
                  if (nw == DWELL) begin
                     nw = 0;
                     ns = (m_state == 2) ? 3 : 1;
                     nt = (m_state == 2) ? MIN : MAX;
                  end
               end
               default: ns = 0;
            endcase
         end
         m_duty = nd; m_target = nt; m_state = ns; m_dwell = nw;
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      chk("duty", duty, m_duty);
      chk("duty_upd", {31'd0, duty_upd}, {31'd0, m_upd});
      chk("at_limit", {31'd0, at_limit}, (m_duty == MIN || m_duty == MAX) ? 32'd1 : 32'd0);
      chk("state_o", {29'd0, state_o}, m_state);
      if (duty_upd) upd_cnt++;
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick();
      frame_tick = 1'b1; step(1); frame_tick = 1'b0;
      last_upd = duty_upd;
      step(1);
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic press(input logic i, input logic d);
      inc_pulse = i; dec_pulse = d; step(1);
      inc_pulse = 1'b0; dec_pulse = 1'b0; step(1);
   endtask

   task automatic do_reset();
      @(posedge clk); #3 rst_a_p = 1'b1;
      #4 rst_a_p = 1'b0;
      mode_auto = 1'b0; hold = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int u0;
      // reset state, idle ticks
      step(2); #2 rst_a_p = 1'b0; @(posedge clk); #1;
      u0 = upd_cnt;
      ticks(3);
      chk("rst_duty", duty, RST);
      chk("rst_state", {29'd0, state_o}, 0);
      chk("rst_limit", {31'd0, at_limit}, 0);
      chk("rst_no_upd", upd_cnt - u0, 0);

      // one inc: 5 ramp steps with strobes, 6th tick silent
      press(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("inc_ramp_duty", duty, (i < 5) ? RST + 1000 * (i + 1) : 80_000);
         chk("inc_ramp_upd", {31'd0, last_upd}, (i < 5) ? 1 : 0);
      end

      // saturation at DUTY_MAX, simultaneous inc+dec ignored
      do_reset();
      repeat (12) press(1'b1, 1'b0);
      ticks(49);
      chk("sat_duty49", duty, 124_000);
      tick();
      chk("sat_duty50", duty, MAX);
      chk("sat_limit", {31'd0, at_limit}, 1);
      ticks(10);
      chk("sat_hold", duty, MAX);
      press(1'b1, 1'b1);
      press(1'b0, 1'b1);
      ticks(6);
      chk("incdec_ignored", duty, 120_000);

      // full auto sweep; buttons ignored
      do_reset();
      mode_auto = 1'b1; step(1);
      chk("auto_enter", {29'd0, state_o}, 1);
      ticks(49);
      chk("auto_up49", duty, 124_000);
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      tick();
      chk("auto_top", duty, MAX);
      chk("auto_dwell_hi", {29'd0, state_o}, 2);
      ticks(24);
      chk("dwell_hi_24", {29'd0, state_o}, 2);
      tick();
      chk("sweep_dn", {29'd0, state_o}, 3);
      ticks(99);
      chk("dn_99", duty, 26_000);
      tick();
      chk("dn_bottom", duty, MIN);
      chk("dwell_lo", {29'd0, state_o}, 4);
      chk("bottom_limit", {31'd0, at_limit}, 1);
      ticks(24);
      chk("dwell_lo_24", {29'd0, state_o}, 4);
      tick();
      chk("resweep_up", {29'd0, state_o}, 1);
      tick();
      chk("resweep_duty", duty, 26_000);

      // leave auto mid-sweep, then hold during a manual ramp
      do_reset();
      mode_auto = 1'b1; step(1);
      ticks(100);
      chk("dn_100k", duty, 100_000);
      mode_auto = 1'b0; step(1);
      chk("exit_manual", {29'd0, state_o}, 0);
      u0 = upd_cnt;
      ticks(3);
      chk("exit_stays", duty, 100_000);
      chk("exit_no_upd", upd_cnt - u0, 0);
      press(1'b1, 1'b0);
      hold = 1'b1;
      ticks(5);
      chk("hold_frozen", duty, 100_000);
      hold = 1'b0;
      tick();
      chk("hold_resume", duty, 101_000);

      // asynchronous reset in the middle of a ramp
      do_reset();
      repeat (7) press(1'b1, 1'b0);
      ticks(15);
      chk("pre_rst_duty", duty, 90_000);
      #2 rst_a_p = 1'b1;
      #1;
      chk("async_duty", duty, RST);
      chk("async_state", {29'd0, state_o}, 0);
      chk("async_upd", {31'd0, duty_upd}, 0);
      #3 rst_a_p = 1'b0;
      @(posedge clk); #1;
      u0 = upd_cnt;
      ticks(5);
      chk("post_rst_no_upd", upd_cnt - u0, 0);

      // random stimulus against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         inc_pulse  = ($urandom_range(0, 5) == 0);
         dec_pulse  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 29) == 0)  hold = ~hold;
         if ($urandom_range(0, 299) == 0) mode_auto = ~mode_auto;
         step(1);
      end
      frame_tick = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0; hold = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
